qdiv_seq: RTL and testbench
===========================

Name: qdiv_seq

Overview:
Parametrised sequential fixed-point divider that generates one quotient bit per clock (radix-2 restoring). It is the handshaked successor to the existing start/complete divider. Operands and result are sign-magnitude Qm.n: MSB is the sign, the low N-1 bits are the magnitude, and Q of those are fractional. Adds valid/ready flow control, divide-by-zero detection, overflow saturation and synchronous reset. It sits in the fixed-point arithmetic datapath alongside the multiplier.

Parameters:
N, 32, total word width including the sign bit.
Q, 15, fractional bit count; legal range 1 <= Q <= N-2.

Ports:
i_clk  in  1  clock; all logic on the rising edge.
i_rst  in  1  synchronous, active-high reset.
i_valid  in  1  operand pair valid.
o_ready  out  1  block can accept operands.
i_dividend  in  N  sign-magnitude dividend.
i_divisor  in  N  sign-magnitude divisor.
o_valid  out  1  result valid.
i_ready  in  1  consumer accepts the result.
o_quotient  out  N  sign-magnitude quotient.
o_overflow  out  1  quotient magnitude saturated.
o_div_zero  out  1  divisor magnitude was zero.

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous and active-high.
- Reset values: state IDLE; o_ready=1; o_valid=0; o_quotient=0; o_overflow=0; o_div_zero=0; all working registers 0.
- States:
  - IDLE: o_ready=1. On i_valid, capture operands. Go to DONE if the divisor magnitude is zero, otherwise go to BUSY.
  - BUSY: o_ready=0. ITER = N+Q-1 cycles, one quotient bit per cycle, MSB first. After the last iteration go to DONE.
  - DONE: o_valid=1 and all outputs held stable. When i_ready=1, return to IDLE on the next cycle.
- Operands are accepted only in IDLE. There is no accept in the same cycle as the DONE->IDLE hand-off, so minimum throughput is one result per ITER+2 cycles.
- Latency: o_valid first goes high ITER+1 cycles after the accepting edge (47 for the defaults). Divide-by-zero: o_valid goes high 1 cycle after the accept.
- Arithmetic:
  - Working dividend is N+Q-1 bits, holding the dividend magnitude shifted left by Q.
  - Working divisor is 2N+Q-3 bits, holding the divisor magnitude left-aligned; it shifts right by 1 each iteration.
  - When dividend >= divisor: subtract and set the quotient bit.
- Overflow: if any raw quotient bit at or above position N-1 is set, assert o_overflow and clamp the magnitude to 2^(N-1)-1.
- Divide-by-zero: a divisor magnitude of 0 includes 0x80..0 (negative zero). Result: o_div_zero=1, o_overflow=0, magnitude all ones.
- Sign: the result sign is the XOR of the operand signs. The sign is forced to 0 when the result magnitude is zero (no negative-zero output).
- i_valid while BUSY or DONE is ignored. The producer must hold its operands until o_ready & i_valid.
- i_rst mid-operation (BUSY or DONE) abandons the computation, drops o_valid next cycle and returns to the reset values.
- Flags are valid only while o_valid=1 and are cleared when leaving DONE.

Optional Feature:
- Macro: QDIV_ROUND_EN.
- Defined:
  - Run ITER+1 iterations, producing one guard bit below the LSB.
  - Add the guard bit to the magnitude (round half away from zero).
  - If the increment reaches 2^(N-1), set o_overflow and saturate.
  - Latency becomes ITER+2.
- Undefined: truncate toward zero, latency as above.

Decomposition:
- Shared package qdiv_pkg:
  - state encoding (IDLE/BUSY/DONE);
  - localparams ITER and working widths, computed from N and Q;
  - sign-magnitude helper functions: magnitude extract, is-zero, saturate.
- One natural sub-module, qdiv_iter_core:
  - the shift/compare/subtract datapath, with counter and working registers;
  - FSM and handshake stay in qdiv_seq.

Test Plan (defaults N=32, Q=15, no rounding unless stated):
- 1.0/1.0: 0x00008000 / 0x00008000 -> o_quotient=0x00008000; flags 0; o_valid 47 cycles after accept.
- 3.0/-2.0: 0x00018000 / 0x80010000 -> 0x8000C000 (-1.5). Also 0x80000000 / 0x00008000 -> 0x00000000 (sign cleared).
- Divide by zero: 0x80008000 / 0x80000000 -> o_div_zero=1, o_quotient=0x7FFFFFFF, o_valid 1 cycle after accept.
- Overflow: 0x7FFFFFFF / 0x00000001 -> o_overflow=1, o_quotient=0x7FFFFFFF.
- Backpressure and reset:
  - Hold i_ready=0 for 10 cycles in DONE -> outputs stable, o_ready=0, i_valid ignored.
  - Assert i_rst at BUSY iteration 20 -> next cycle o_valid=0, o_ready=1, outputs 0.
- Rounding: 0x00008000 / 0x00018000 -> 0x00002AAA without QDIV_ROUND_EN; 0x00002AAB with it, latency 48.

Source files
------------

// File: rtl/qdiv_pkg.sv
// Shared definitions for the sequential sign-magnitude Qm.n divider.
// QDIV_ROUND_EN adds one guard-bit iteration for round-half-away-from-zero.
package qdiv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int N_DEF = 32;
   localparam int Q_DEF = 15;
   localparam int MAXW  = 64;

   typedef logic [MAXW-1:0] word_t;

   function automatic int calc_iter(input int n, input int q);
      return n + q - 1;
   endfunction

   // The working dividend width doubles as the iteration count.
   function automatic int calc_wd(input int n, input int q);
`ifdef QDIV_ROUND_EN
      return calc_iter(n, q) + 1;
`else
      return calc_iter(n, q);
`endif
   endfunction

   function automatic int calc_wv(input int n, input int q);
      return calc_wd(n, q) + n - 2;
   endfunction

   localparam int ITER = calc_iter(N_DEF, Q_DEF);
   localparam int WD   = calc_wd(N_DEF, Q_DEF);
   localparam int WV   = calc_wv(N_DEF, Q_DEF);

   function automatic word_t sm_sat(input int n);
      return (word_t'(1) << (n - 1)) - word_t'(1);
   endfunction

   function automatic word_t sm_mag(input word_t w, input int n);
      return w & sm_sat(n);
   endfunction

   function automatic logic sm_is_zero(input word_t w, input int n);
      return sm_mag(w, n) == '0;
   endfunction

endpackage

// File: rtl/qdiv_if.sv
// Operand/result handshake bundle for qdiv_seq; names are as seen from the divider.
interface qdiv_if #(parameter int N = 32);
   logic         i_valid;
   logic         o_ready;
   logic [N-1:0] i_dividend;
   logic [N-1:0] i_divisor;
   logic         o_valid;
   logic         i_ready;
   logic [N-1:0] o_quotient;
   logic         o_overflow;
   logic         o_div_zero;

   modport master (
      output i_valid, i_dividend, i_divisor, i_ready,
      input  o_ready, o_valid, o_quotient, o_overflow, o_div_zero
   );

   modport slave (
      input  i_valid, i_dividend, i_divisor, i_ready,
      output o_ready, o_valid, o_quotient, o_overflow, o_div_zero
   );
endinterface

// File: rtl/qdiv_iter_core.sv
// Radix-2 restoring shift/compare/subtract datapath, one raw quotient bit per clock, MSB first.
module qdiv_iter_core import qdiv_pkg::*; #(
   parameter int N = N_DEF,
   parameter int Q = Q_DEF
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_load,
   input  logic [N-2:0]             i_dvd_mag,
   input  logic [N-2:0]             i_dvs_mag,
   output logic                     o_last,
   output logic [calc_wd(N,Q)-1:0]  o_quo_raw
);
   localparam int M  = N - 1;
   localparam int LW = calc_wd(N, Q);
   localparam int LV = calc_wv(N, Q);
   localparam int CW = $clog2(LW + 1);

   logic [CW-1:0] r_cnt;
   logic [LW-1:0] r_rem;
   logic [LW-1:0] r_quo;
   logic [LV-1:0] r_div;

   logic [LV-1:0] w_rem_ext;
   logic          w_ge;
   logic [LW-1:0] w_diff;

   assign w_rem_ext = {{(LV-LW){1'b0}}, r_rem};
   assign w_ge      = w_rem_ext >= r_div;
   // When w_ge holds the difference is below 2^LW, so the low bits suffice.
   assign w_diff    = r_rem - r_div[LW-1:0];
   assign o_last    = r_cnt == CW'(1);
   assign o_quo_raw = r_quo;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
         r_rem <= '0;
         r_quo <= '0;
         r_div <= '0;
      end else if (i_load) begin
         r_rem <= {i_dvd_mag, {(LW-M){1'b0}}};
         r_div <= {i_dvs_mag, {(LV-M){1'b0}}};
         r_quo <= '0;
         r_cnt <= CW'(LW);
      end else if (r_cnt != '0) begin
         r_rem <= w_ge ? w_diff : r_rem;
         r_quo <= {r_quo[LW-2:0], w_ge};
         r_div <= r_div >> 1;
         r_cnt <= r_cnt - CW'(1);
      end
   end
endmodule

// File: rtl/qdiv_seq.sv
// Handshaked sign-magnitude Qm.n divider: FSM, sign/flag handling, overflow saturation.
// Build with QDIV_ROUND_EN to round half away from zero instead of truncating.
//   state | meaning
//   IDLE  | o_ready=1, waiting for an operand pair
//   BUSY  | iterating, one quotient bit per cycle
//   DONE  | o_valid=1, result held until i_ready
module qdiv_seq import qdiv_pkg::*; #(
   parameter int N = N_DEF,
   parameter int Q = Q_DEF
) (
   input  logic   i_clk,
   input  logic   i_rst,
   qdiv_if.slave  bus
);
   localparam int M   = N - 1;
   localparam int LW  = calc_wd(N, Q);
   localparam logic [M-1:0] SAT = M'(sm_sat(N));

   state_t        r_state;
   state_t        w_next;
   logic          r_sign;
   logic          r_div_zero;

   logic          w_accept;
   logic          w_release;
   logic          w_load;
   logic          w_last;
   logic          w_dz_in;
   logic          w_sign_in;
   logic          w_ovf;
   logic [M-1:0]  w_dvd_mag;
   logic [M-1:0]  w_dvs_mag;
   logic [M-1:0]  w_mag;
   logic [M-1:0]  w_mag_out;
   logic [LW-1:0] w_quo_raw;

   assign w_dvd_mag = M'(sm_mag(MAXW'(bus.i_dividend), N));
   assign w_dvs_mag = M'(sm_mag(MAXW'(bus.i_divisor), N));
   assign w_dz_in   = sm_is_zero(MAXW'(bus.i_divisor), N);
   assign w_sign_in = bus.i_dividend[N-1] ^ bus.i_divisor[N-1];
   assign w_load    = w_accept & ~w_dz_in;

   qdiv_iter_core #(.N(N), .Q(Q)) u_core (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_load    (w_load),
      .i_dvd_mag (w_dvd_mag),
      .i_dvs_mag (w_dvs_mag),
      .o_last    (w_last),
      .o_quo_raw (w_quo_raw)
   );

`ifdef QDIV_ROUND_EN
   logic [LW-2:0] w_q_trunc;
   logic [M:0]    w_sum;

   // Raw LSB is the guard bit; adding it rounds half away from zero on the magnitude.
   assign w_q_trunc = w_quo_raw[LW-1:1];
   assign w_sum     = {1'b0, w_q_trunc[M-1:0]} + {{M{1'b0}}, w_quo_raw[0]};
   assign w_ovf     = (|w_q_trunc[LW-2:M]) | w_sum[M];
   assign w_mag     = w_ovf ? SAT : w_sum[M-1:0];
`else
   assign w_ovf     = |w_quo_raw[LW-1:M];
   assign w_mag     = w_ovf ? SAT : w_quo_raw[M-1:0];
`endif

   assign w_mag_out = r_div_zero ? SAT : w_mag;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (bus.i_valid) w_next = w_dz_in ? ST_DONE : ST_BUSY;
         ST_BUSY: if (w_last)      w_next = ST_DONE;
         ST_DONE: if (bus.i_ready) w_next = ST_IDLE;
         default:                  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.o_ready    = 1'b0;
      bus.o_valid    = 1'b0;
      bus.o_quotient = '0;
      bus.o_overflow = 1'b0;
      bus.o_div_zero = 1'b0;
      w_accept       = 1'b0;
      w_release      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            bus.o_ready = 1'b1;
            w_accept    = bus.i_valid;
         end
         ST_DONE: begin
            bus.o_valid    = 1'b1;
            bus.o_quotient = {r_sign & (|w_mag_out), w_mag_out};
            bus.o_overflow = ~r_div_zero & w_ovf;
            bus.o_div_zero = r_div_zero;
            w_release      = bus.i_ready;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sign     <= 1'b0;
         r_div_zero <= 1'b0;
      end else if (w_accept) begin
         r_sign     <= w_sign_in;
         r_div_zero <= w_dz_in;
      end else if (w_release) begin
         r_sign     <= 1'b0;
         r_div_zero <= 1'b0;
      end
   end
endmodule

// File: tb/tb_qdiv_seq.sv
// Scoreboard bench for qdiv_seq (N=32, Q=15); define QDIV_ROUND_EN for the rounding build.
module tb_qdiv_seq;
   localparam int N    = 32;
   localparam int Q    = 15;
   localparam int ITER = N + Q - 1;
`ifdef QDIV_ROUND_EN
   localparam int LAT  = ITER + 2;
`else
   localparam int LAT  = ITER + 1;
`endif

   typedef struct {
      logic [31:0] q;
      logic        ovf;
      logic        dz;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   qdiv_if #(.N(N)) bus ();
   qdiv_seq #(.N(N), .Q(Q)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference result straight from integer division of the magnitudes.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [63:0] dm, vm, raw;
      logic        s;
      dm    = {33'b0, a[30:0]};
      vm    = {33'b0, b[30:0]};
      s     = a[31] ^ b[31];
      e.ovf = 1'b0;
      e.dz  = 1'b0;
      if (vm == 64'd0) begin
         e.dz  = 1'b1;
         e.q   = {s, 31'h7FFF_FFFF};
         e.lat = 1;
      end else begin
`ifdef QDIV_ROUND_EN
         raw = (dm << (Q + 1)) / vm;
         raw = (raw >> 1) + (raw & 64'd1);
`else
         raw = (dm << Q) / vm;
`endif
         if (raw > 64'h7FFF_FFFF) begin
            e.ovf = 1'b1;
            raw   = 64'h7FFF_FFFF;
         end
         e.q   = {s & (raw != 64'd0), raw[30:0]};
         e.lat = LAT;
      end
      return e;
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
      exp_t e;
      int   lat;
      logic any_rdy;
      @(negedge clk);
      bus.i_ready    = (hold == 0);
      bus.i_valid    = 1'b1;
      bus.i_dividend = a;
      bus.i_divisor  = b;
      @(posedge clk);
      sb.push_back(model(a, b));
      #1;
      // Keep i_valid high with fresh operands: the divider must ignore them.
      bus.i_dividend = $urandom;
      bus.i_divisor  = $urandom;
      lat     = 1;
      any_rdy = 1'b0;
      while (!bus.o_valid && lat < 200) begin
         any_rdy |= bus.o_ready;
         @(posedge clk);
         #1;
         lat++;
      end
      if (sb.size() == 0) begin
         chk("sb_empty", 32'(sb.size()), 32'd1);
         e = model(a, b);
      end else begin
         e = sb.pop_front();
      end
      chk("latency",   lat,               e.lat);
      chk("quotient",  bus.o_quotient,    e.q);
      chk("overflow",  32'(bus.o_overflow), 32'(e.ovf));
      chk("div_zero",  32'(bus.o_div_zero), 32'(e.dz));
      chk("busy_ready", 32'(any_rdy),     32'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", 32'(bus.o_valid), 32'd1);
         chk("hold_ready", 32'(bus.o_ready), 32'd0);
         chk("hold_q",     bus.o_quotient,   e.q);
         chk("hold_flags", 32'({bus.o_overflow, bus.o_div_zero}), 32'({e.ovf, e.dz}));
      end
      if (hold > 0) begin
         @(negedge clk);
         bus.i_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("rel_valid", 32'(bus.o_valid), 32'd0);
      chk("rel_ready", 32'(bus.o_ready), 32'd1);
      chk("rel_q",     bus.o_quotient,   32'd0);
      chk("rel_flags", 32'({bus.o_overflow, bus.o_div_zero}), 32'd0);
      bus.i_valid = 1'b0;
   endtask

   task automatic reset_mid();
      @(negedge clk);
      bus.i_ready    = 1'b1;
      bus.i_valid    = 1'b1;
      bus.i_dividend = 32'h0001_8000;
      bus.i_divisor  = 32'h8001_0000;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_valid", 32'(bus.o_valid), 32'd0);
      chk("mid_rst_ready", 32'(bus.o_ready), 32'd1);
      chk("mid_rst_q",     bus.o_quotient,   32'd0);
      chk("mid_rst_flags", 32'({bus.o_overflow, bus.o_div_zero}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] a, b;
      bus.i_valid    = 1'b0;
      bus.i_ready    = 1'b1;
      bus.i_dividend = '0;
      bus.i_divisor  = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(bus.o_ready), 32'd1);
      chk("rst_valid", 32'(bus.o_valid), 32'd0);
      chk("rst_q",     bus.o_quotient,   32'd0);
      chk("rst_flags", 32'({bus.o_overflow, bus.o_div_zero}), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op(32'h0000_8000, 32'h0000_8000, 0);
      run_op(32'h0001_8000, 32'h8001_0000, 0);
      run_op(32'h8000_0000, 32'h0000_8000, 0);
      run_op(32'h8000_8000, 32'h8000_0000, 0);
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 0);
      run_op(32'h0000_8000, 32'h0001_8000, 10);
      run_op(32'h8000_8000, 32'h0000_0000, 3);
      reset_mid();
      run_op(32'h0001_8000, 32'h8001_0000, 2);
      for (int i = 0; i < 10; i++) begin
         a     = $urandom >> $urandom_range(0, 24);
         b     = $urandom >> $urandom_range(0, 24);
         a[31] = 1'($urandom_range(0, 1));
         b[31] = 1'($urandom_range(0, 1));
         run_op(a, b, $urandom_range(0, 2));
      end
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
